// File: rtl/instruction_fetch.sv
// Fetch stage and IF/ID pipeline register: one outstanding imem request, a one-entry
// skid buffer for responses that arrive while decode is stalled, and delayed-slot redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_if, pc_if_next;
  logic [31:0] req_pc, req_pc_next;
  logic [31:0] buf_pc, buf_pc_next;
  logic [31:0] buf_instr, buf_instr_next;
  logic        buf_valid, buf_valid_next;
  logic [31:0] pc_id_next, instr_id_next;
  logic        id_valid_next;
  logic        redir_pend, redir_pend_next;
  logic [31:0] redir_pc, redir_pc_next;

  logic        adv;
  logic        redirect_now;
  logic [31:0] slot;
  logic [31:0] target;

  assign adv          = ~stall | ~id_valid;
  assign redirect_now = id_valid & ~stall & (jump_reg | jump_target | jump_branch);
  assign slot         = pc_id + 32'd4;

  // jump_reg outranks jump_target, which outranks jump_branch
  always_comb begin
    target = slot + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
    if (jump_reg) begin
      target = jr_pc;
    end else if (jump_target) begin
      target = {slot[31:28], instr_id[25:0], 2'b00};
    end
  end

  assign imem_req  = (state == S_REQ) & ~rst;
  assign imem_addr = pc_if;

  always_comb begin
    state_next      = state;
    pc_if_next      = pc_if;
    req_pc_next     = req_pc;
    buf_pc_next     = buf_pc;
    buf_instr_next  = buf_instr;
    buf_valid_next  = buf_valid;
    pc_id_next      = pc_id;
    instr_id_next   = instr_id;
    id_valid_next   = id_valid;
    redir_pend_next = redir_pend;
    redir_pc_next   = redir_pc;

    case (state)
      S_REQ: begin
        // The request for pc_if goes out this cycle; pick the address after it.
        req_pc_next     = pc_if;
        state_next      = S_WAIT;
        redir_pend_next = 1'b0;
        if (redirect_now && (pc_if == slot)) begin
          pc_if_next = target;
        end else if (redir_pend) begin
          pc_if_next = redir_pc;
        end else begin
          pc_if_next = pc_if + 32'd4;
        end
        if (adv) begin
          id_valid_next = 1'b0;
          instr_id_next = 32'h0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (adv) begin
            pc_id_next    = req_pc;
            instr_id_next = imem_rdata;
            id_valid_next = 1'b1;
            state_next    = S_REQ;
          end else begin
            buf_pc_next    = req_pc;
            buf_instr_next = imem_rdata;
            buf_valid_next = 1'b1;
            state_next     = S_HOLD;
          end
        end else if (adv) begin
          id_valid_next = 1'b0;
          instr_id_next = 32'h0;
        end
      end
      S_HOLD: begin
        if (adv) begin
          pc_id_next     = buf_pc;
          instr_id_next  = buf_instr;
          id_valid_next  = buf_valid;
          buf_valid_next = 1'b0;
          state_next     = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase

    // Slot already requested: steer the fetch after it straight to the target.
    if ((state != S_REQ) && redirect_now) begin
      if (pc_if == slot + 32'd4) begin
        pc_if_next = target;
      end else if (pc_if == slot) begin
        redir_pend_next = 1'b1;
        redir_pc_next   = target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc_if      <= RESET_PC;
      req_pc     <= RESET_PC;
      buf_pc     <= 32'h0;
      buf_instr  <= 32'h0;
      buf_valid  <= 1'b0;
      pc_id      <= 32'h0;
      instr_id   <= 32'h0;
      id_valid   <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc   <= 32'h0;
    end else begin
      state      <= state_next;
      pc_if      <= pc_if_next;
      req_pc     <= req_pc_next;
      buf_pc     <= buf_pc_next;
      buf_instr  <= buf_instr_next;
      buf_valid  <= buf_valid_next;
      pc_id      <= pc_id_next;
      instr_id   <= instr_id_next;
      id_valid   <= id_valid_next;
      redir_pend <= redir_pend_next;
      redir_pc   <= redir_pc_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: an architectural program-order model predicts every
// instruction decode consumes; a random-latency memory and a scoreboard monitor check the DUT.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump_branch, jump_target, jump_reg;
  logic [31:0] jr_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id, instr_id;
  logic        id_valid;

  int compared   = 0;
  int mismatched = 0;
  int consumed_n = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  // architectural model state
  logic [31:0] model_pc;
  logic        pend_valid;
  logic [31:0] pend_target;

  // memory responder state
  logic        rsp_busy = 1'b0;
  int          rsp_cnt  = 0;
  logic [31:0] rsp_addr = 32'h0;
  logic        stale    = 1'b0;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_branch (jump_branch),
    .jump_target (jump_target),
    .jump_reg    (jump_reg),
    .jr_pc       (jr_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .id_valid    (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_pc    = RESET_PC;
    pend_valid  = 1'b0;
    pend_target = 32'h0;
  endtask

  // Called at a falling edge: chooses this cycle's decode inputs and, when decode consumes
  // the ID instruction, records what program order says that instruction must be.
  task automatic drive_cycle();
    logic [2:0]  j;
    logic [31:0] ins, p4, tgt, nxt;
    exp_t        e;
    stall = ($urandom_range(0, 99) < 30);
    jr_pc = $urandom & 32'hFFFF_FFFC;
    j     = 3'($urandom);
    if (id_valid && !stall) begin
      ins     = mem_word(model_pc);
      e.pc    = model_pc;
      e.instr = ins;
      exp_q.push_back(e);
      p4 = model_pc + 32'd4;
      if (pend_valid) begin
        // delay-slot instruction: never a control transfer itself
        j          = 3'b000;
        nxt        = pend_target;
        pend_valid = 1'b0;
      end else begin
        if ($urandom_range(0, 99) >= 25) j = 3'b000;
        nxt = p4;
        if (j != 3'b000) begin
          if (j[2])      tgt = jr_pc;
          else if (j[1]) tgt = {p4[31:28], ins[25:0], 2'b00};
          else           tgt = p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
          pend_valid  = 1'b1;
          pend_target = tgt;
        end
      end
      model_pc = nxt;
    end
    {jump_reg, jump_target, jump_branch} = j;
  endtask

  // Memory: random latency 1..4 cycles, one request at a time; a request cut off by reset
  // comes back as a stale word in the first cycle after release.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rst) begin
        if (rsp_busy) begin
          rsp_busy = 1'b0;
          stale    = 1'b1;
        end
      end else begin
        if (stale) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hDEAD_BEEF;
          stale       = 1'b0;
        end else if (rsp_busy) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rsp_addr);
            rsp_busy    = 1'b0;
          end
        end
        if (imem_req) begin
          check("single_outstanding", {31'h0, rsp_busy}, 32'h0);
          rsp_busy = 1'b1;
          rsp_addr = imem_addr;
          rsp_cnt  = $urandom_range(1, 4);
        end
      end
    end
  end

  // Scoreboard monitor: compares every instruction decode consumes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (id_valid && !stall) begin
          consumed_n++;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_id: got pc %h instr %h, expected no instruction", pc_id, instr_id);
          end else begin
            e = exp_q.pop_front();
            $display("ID consume pc=%h instr=%h expect pc=%h instr=%h", pc_id, instr_id, e.pc, e.instr);
            check("id_pc", pc_id, e.pc);
            check("id_instr", instr_id, e.instr);
          end
        end else if (!id_valid) begin
          check("bubble_nop", instr_id, 32'h0);
        end
      end
    end
  end

  initial begin
    logic found;
    rst         = 1'b1;
    stall       = 1'b0;
    jump_branch = 1'b0;
    jump_target = 1'b0;
    jump_reg    = 1'b0;
    jr_pc       = 32'h0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_id_valid", {31'h0, id_valid}, 32'h0);
    check("reset_instr_id", instr_id, 32'h0);
    check("reset_pc_id", pc_id, 32'h0);
    check("reset_imem_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;

    @(negedge clk);
    #3;
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, RESET_PC);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      drive_cycle();
    end

    // Reset while a request is in flight and its response is still at least a cycle away.
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      drive_cycle();
      #3;
      if (rsp_busy && rsp_cnt >= 2) found = 1'b1;
    end
    check("reset_window_found", {31'h0, found}, 32'h1);
    rst      = 1'b1;
    stall    = 1'b0;
    jump_reg = 1'b1;
    #1;
    check("async_rst_id_valid", {31'h0, id_valid}, 32'h0);
    check("async_rst_instr_id", instr_id, 32'h0);
    check("async_rst_pc_id", pc_id, 32'h0);
    check("async_rst_imem_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    jump_reg    = 1'b0;
    jump_target = 1'b0;
    jump_branch = 1'b0;
    model_reset();
    exp_q.delete();

    @(negedge clk);
    #3;
    check("restart_req", {31'h0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, RESET_PC);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      drive_cycle();
    end

    check("progress", {31'h0, (consumed_n >= 200)}, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
